// File: rtl/iobuf_bank_pkg.sv
// Shared types and constants for the iobuf_bank pad bank.
package iobuf_bank_pkg;

  localparam int TURN_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } iobuf_state_t;

endpackage

// File: rtl/iobuf_sync.sv
// Multi-stage asynchronous-reset synchroniser chain for the receive path.
module iobuf_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/iobuf_bank.sv
// Bidirectional pad bank with direction-turnaround FSM and synchronised receive path.
// Optional contention checker enabled by defining IOBUF_BANK_CONTENTION_EN.
module iobuf_bank
  import iobuf_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  inout  wire  [WIDTH-1:0] IO,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [WIDTH-1:0] tx_oe,
  // 'release' is a reserved word, hence the suffix
  input  logic             release_req,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [1:0]       state,
  output logic             err_contention
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);
  localparam bit NO_TURN = (TURN_CYCLES == 0);
  localparam logic [TURN_CNT_W-1:0] TURN_LOAD =
    (TURN_CYCLES == 0) ? '0 : TURN_CNT_W'(TURN_CYCLES - 1);

  iobuf_state_t          state_q, state_d;
  logic [TURN_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      oe_q, oe_d;
  logic [WIDTH-1:0]      pend_q, pend_d;
  logic                  rel_q, rel_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  accept;

  // A release latched during TURN_ON also blocks acceptance in the first DRIVE cycle
  assign tx_ready = ((state_q == IDLE) || ((state_q == DRIVE) && !rel_q)) && !release_req;
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    oe_d    = oe_q;
    pend_d  = pend_q;
    rel_d   = rel_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        oe_d = '0;
        if (accept) begin
          out_d  = tx_data;
          pend_d = tx_oe;
          if (NO_TURN) begin
            oe_d    = tx_oe;
            state_d = DRIVE;
          end else begin
            state_d = TURN_ON;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN_ON: begin
        if (release_req) rel_d = 1'b1;
        if (cnt_q == '0) begin
          oe_d    = pend_q;
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - TURN_CNT_W'(1);
        end
      end
      DRIVE: begin
        if (release_req || rel_q) begin
          oe_d  = '0;
          rel_d = 1'b0;
          if (NO_TURN) begin
            state_d = IDLE;
          end else begin
            state_d = TURN_OFF;
            cnt_d   = TURN_LOAD;
          end
        end else if (accept) begin
          out_d = tx_data;
          oe_d  = tx_oe;
        end
      end
      TURN_OFF: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - TURN_CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        oe_d    = '0;
      end
    endcase
    if (state_q != IDLE)         fill_d = '0;
    else if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      pend_q  <= '0;
      rel_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      pend_q  <= pend_d;
      rel_q   <= rel_d;
      fill_q  <= fill_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign IO[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

  iobuf_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .CLK  (CLK),
    .nRST (nRST),
    .d    (IO),
    .q    (rx_data)
  );

  assign rx_valid = (state_q == IDLE) && (fill_q == FILL_FULL);
  assign state    = state_q;

`ifdef IOBUF_BANK_CONTENTION_EN
  logic [FILL_W-1:0] stab_q, stab_d;
  logic              err_q, err_d;

  // Compare only once the driven value has had time to reach the synchroniser output
  always_comb begin
    stab_d = stab_q;
    err_d  = err_q;
    if ((state_d != DRIVE) || (oe_d != oe_q) || (out_d != out_q)) stab_d = '0;
    else if (stab_q != FILL_FULL)                                 stab_d = stab_q + FILL_W'(1);
    if ((state_q == DRIVE) && (stab_q == FILL_FULL) && (|((rx_data ^ out_q) & oe_q))) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stab_q <= '0;
      err_q  <= 1'b0;
    end else begin
      stab_q <= stab_d;
      err_q  <= err_d;
    end
  end

  assign err_contention = err_q;
`else
  assign err_contention = 1'b0;
`endif

endmodule

// File: tb/tb_iobuf_bank.sv
// Self-checking bench: directed vector table, contention sequence, randomized run against a reference model.
module tb_iobuf_bank;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid, rel;
  logic [7:0] tx_data, tx_oe, probe;
  logic [7:0] en_a, en_b;
  wire  [7:0] io_a, io_b;
  logic       rdy_a, rdy_b, rxv_a, rxv_b, err_a, err_b;
  logic [7:0] rx_a, rx_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // bench-side pad drivers: drive the probe pattern only where the DUT is expected to float
  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign io_a[i] = en_a[i] ? probe[i] : 1'bz;
    assign io_b[i] = en_b[i] ? probe[i] : 1'bz;
  end

  iobuf_bank #(.WIDTH(8), .SYNC_STAGES(S), .TURN_CYCLES(1)) u_dut_a (
    .CLK(clk), .nRST(rst_n), .IO(io_a), .tx_valid(tx_valid), .tx_ready(rdy_a),
    .tx_data(tx_data), .tx_oe(tx_oe), .release_req(rel), .rx_data(rx_a),
    .rx_valid(rxv_a), .state(st_a), .err_contention(err_a)
  );

  iobuf_bank #(.WIDTH(8), .SYNC_STAGES(S), .TURN_CYCLES(0)) u_dut_b (
    .CLK(clk), .nRST(rst_n), .IO(io_b), .tx_valid(tx_valid), .tx_ready(rdy_b),
    .tx_data(tx_data), .tx_oe(tx_oe), .release_req(rel), .rx_data(rx_b),
    .rx_valid(rxv_b), .state(st_b), .err_contention(err_b)
  );

  // ---------------- reference model (k=0: one dead cycle, k=1: none) ----------------
  int         m_mode [2];
  int         m_left [2];
  int         m_fill [2];
  logic [7:0] m_out  [2];
  logic [7:0] m_oe   [2];
  logic [7:0] m_pend [2];
  bit         m_relp [2];
  logic [7:0] m_hist [2][S];

  function automatic int turn_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [7:0] m_pad(int k);
    return (m_out[k] & m_oe[k]) | (probe & ~m_oe[k]);
  endfunction

  function automatic bit m_ready(int k);
    return ((m_mode[k] == 0) || (m_mode[k] == 2 && !m_relp[k])) && !rel;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_fill[k] = 0;
      m_out[k] = 8'h00; m_oe[k] = 8'h00; m_pend[k] = 8'h00; m_relp[k] = 1'b0;
      for (int j = 0; j < S; j++) m_hist[k][j] = 8'h00;
    end
  endtask

  task automatic m_step(int k);
    logic [7:0] pad;
    bit         acc;
    int         tc;
    tc  = turn_of(k);
    pad = m_pad(k);
    acc = tx_valid && m_ready(k);
    m_fill[k] = (m_mode[k] == 0) ? ((m_fill[k] < S) ? m_fill[k] + 1 : S) : 0;
    for (int j = S - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = pad;
    case (m_mode[k])
      0: if (acc) begin
        m_out[k] = tx_data; m_pend[k] = tx_oe;
        if (tc == 0) begin m_oe[k] = tx_oe; m_mode[k] = 2; end
        else begin m_mode[k] = 1; m_left[k] = tc; end
      end
      1: begin
        if (rel) m_relp[k] = 1'b1;
        m_left[k]--;
        if (m_left[k] == 0) begin m_oe[k] = m_pend[k]; m_mode[k] = 2; end
      end
      2: if (rel || m_relp[k]) begin
        m_oe[k] = 8'h00; m_relp[k] = 1'b0;
        if (tc == 0) m_mode[k] = 0;
        else begin m_mode[k] = 3; m_left[k] = tc; end
      end else if (acc) begin
        m_out[k] = tx_data; m_oe[k] = tx_oe;
      end
      default: begin
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 0;
      end
    endcase
  endtask

  // ---------------- bench utilities ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_en();
    en_a = ~m_oe[0];
    en_b = ~m_oe[1];
  endtask

  task automatic check_model(int k);
    logic [1:0] st; logic [7:0] io, rx; logic rdy, rxv, err;
    if (k == 0) begin st = st_a; io = io_a; rx = rx_a; rdy = rdy_a; rxv = rxv_a; err = err_a; end
    else        begin st = st_b; io = io_b; rx = rx_b; rdy = rdy_b; rxv = rxv_b; err = err_b; end
    chk($sformatf("model_state[%0d]", k), {6'b0, st}, 8'(m_mode[k]));
    chk($sformatf("model_io[%0d]", k), io, m_pad(k));
    chk($sformatf("model_ready[%0d]", k), {7'b0, rdy}, {7'b0, m_ready(k)});
    chk($sformatf("model_rxvalid[%0d]", k), {7'b0, rxv}, {7'b0, (m_mode[k] == 0) && (m_fill[k] == S)});
    chk($sformatf("model_rxdata[%0d]", k), rx, m_hist[k][S-1]);
    chk($sformatf("model_err[%0d]", k), {7'b0, err}, 8'h00);
  endtask

  task automatic apply(logic v, logic r, logic [7:0] d, logic [7:0] o, logic [7:0] p);
    tx_valid = v; rel = r; tx_data = d; tx_oe = o; probe = p;
    drive_en();
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    drive_en();
  endtask

  // asserted between edges: pads must float at once, before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    drive_en();
    #1;
    chk("reset_float_a", io_a, probe);
    chk("reset_float_b", io_b, probe);
    check_model(0);
    check_model(1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table (expectations for DUT A; state/io for DUT B) ----------------
  typedef struct {
    logic       v, r;
    logic [7:0] d, o, p;
    logic [1:0] st_a;
    logic [7:0] io_a;
    logic       rdy_a, rxv_a;
    logic [1:0] st_b;
    logic [7:0] io_b;
  } vec_t;

  function automatic vec_t mk(logic v, logic r, logic [7:0] d, logic [7:0] o, logic [7:0] p,
                              logic [1:0] sa, logic [7:0] ia, logic ra, logic xa,
                              logic [1:0] sb, logic [7:0] ib);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.o = o; t.p = p;
    t.st_a = sa; t.io_a = ia; t.rdy_a = ra; t.rxv_a = xa; t.st_b = sb; t.io_b = ib;
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 2'd0, 8'hA5, 1'b1, 1'b0, 2'd0, 8'hA5);
    tbl[1]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 2'd0, 8'hA5, 1'b1, 1'b0, 2'd0, 8'hA5);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 2'd0, 8'hA5, 1'b1, 1'b1, 2'd0, 8'hA5);
    tbl[3]  = mk(1'b1, 1'b0, 8'h3C, 8'hFF, 8'hA5, 2'd0, 8'hA5, 1'b1, 1'b1, 2'd0, 8'hA5);
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 2'd1, 8'hA5, 1'b0, 1'b0, 2'd2, 8'h3C);
    tbl[5]  = mk(1'b1, 1'b0, 8'h55, 8'hFF, 8'hA5, 2'd2, 8'h3C, 1'b1, 1'b0, 2'd2, 8'h3C);
    tbl[6]  = mk(1'b1, 1'b0, 8'hAA, 8'hFF, 8'hA5, 2'd2, 8'h55, 1'b1, 1'b0, 2'd2, 8'h55);
    tbl[7]  = mk(1'b1, 1'b1, 8'h00, 8'hFF, 8'hA5, 2'd2, 8'hAA, 1'b0, 1'b0, 2'd2, 8'hAA);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd3, 8'h5A, 1'b0, 1'b0, 2'd0, 8'h5A);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'h5A);
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'h5A);
    tbl[11] = mk(1'b1, 1'b0, 8'hFF, 8'h0F, 8'h5A, 2'd0, 8'h5A, 1'b1, 1'b1, 2'd0, 8'h5A);
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd1, 8'h5A, 1'b0, 1'b0, 2'd2, 8'h5F);
    tbl[13] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd2, 8'h5F, 1'b1, 1'b0, 2'd2, 8'h5F);
    tbl[14] = mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 2'd2, 8'h5F, 1'b0, 1'b0, 2'd2, 8'h5F);
    tbl[15] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd3, 8'h5A, 1'b0, 1'b0, 2'd0, 8'h5A);
    tbl[16] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd0, 8'h5A, 1'b1, 1'b0, 2'd0, 8'h5A);

    rst_n = 1'b0;
    apply(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5);
    m_reset();
    drive_en();
    #2;
    check_model(0);
    check_model(1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].o, tbl[i].p);
      @(negedge clk);
      check_model(0);
      check_model(1);
      chk($sformatf("vec%0d_state_a", i), {6'b0, st_a}, {6'b0, tbl[i].st_a});
      chk($sformatf("vec%0d_io_a", i), io_a, tbl[i].io_a);
      chk($sformatf("vec%0d_ready_a", i), {7'b0, rdy_a}, {7'b0, tbl[i].rdy_a});
      chk($sformatf("vec%0d_rxvalid_a", i), {7'b0, rxv_a}, {7'b0, tbl[i].rxv_a});
      chk($sformatf("vec%0d_rxdata_a", i), rx_a, (i >= 2) ? tbl[i-2].io_a : 8'h00);
      chk($sformatf("vec%0d_state_b", i), {6'b0, st_b}, {6'b0, tbl[i].st_b});
      chk($sformatf("vec%0d_io_b", i), io_b, tbl[i].io_b);
      tick();
    end

`ifdef IOBUF_BANK_CONTENTION_EN
    do_reset();
    en_a = 8'h00;
    en_b = 8'h00;
    tx_valid = 1'b1; rel = 1'b0; tx_data = 8'h01; tx_oe = 8'hFF;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    force io_a[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("contention_set_a", {7'b0, err_a}, 8'h01);
    chk("contention_clean_b", {7'b0, err_b}, 8'h00);
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    repeat (3) @(posedge clk);
    release io_a[0];
    @(negedge clk);
    chk("contention_sticky_a", {7'b0, err_a}, 8'h01);
    do_reset();
    chk("contention_cleared_a", {7'b0, err_a}, 8'h00);
`endif

    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [7:0] o;
      if ($urandom_range(0, 199) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       o = 8'hFF;
        1:       o = 8'h00;
        default: o = 8'($urandom);
      endcase
      apply(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 8'($urandom), o, 8'($urandom));
      @(negedge clk);
      check_model(0);
      check_model(1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
